// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, opcode width and the loader
// handshake FSM encoding. The ALU imports the same opcode constants.
package alu_pkg;

  localparam int unsigned OP_SIZE = 6;

  localparam logic [OP_SIZE-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_SIZE-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_SIZE-1:0] OP_AND = 6'b100100;
  localparam logic [OP_SIZE-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_SIZE-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_SIZE-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_SIZE-1:0] OP_SRL = 6'b000010;
  localparam logic [OP_SIZE-1:0] OP_NOR = 6'b100111;

  typedef enum logic {
    COLLECT = 1'b0,
    VALID   = 1'b1
  } loader_state_e;

  // True when op is one of the eight supported ALU operations.
  function automatic logic is_valid_opcode(input logic [OP_SIZE-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter,
// debounced level and a registered single-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;

  // Bring the raw button into the clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_btn;
      sync_q <= meta_q;
    end
  end

  // Accept a level change only after it has been stable long enough.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    pulse_d = level_d & ~level_q;
  end

  // Counter, debounced level and press pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_pulse = pulse_q;

endmodule

// File: rtl/alu_operand_loader.sv
// ALU operand loader: captures A, B and opcode from switches on debounced
// button presses and presents them to the ALU with a valid/ready handshake.
// Optional build macro ALU_LOADER_OPCODE_CHECK_EN rejects unsupported
// opcodes and flags them on o_err.
module alu_operand_loader #(
  parameter int unsigned SIZE            = 9,
  parameter int unsigned OP_SIZE         = alu_pkg::OP_SIZE,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [SIZE-1:0]    i_sw,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  input  logic               i_ready,
  output logic [SIZE-1:0]    o_a,
  output logic [SIZE-1:0]    o_b,
  output logic [OP_SIZE-1:0] o_opcode,
  output logic               o_valid,
  output logic [2:0]         o_loaded
`ifdef ALU_LOADER_OPCODE_CHECK_EN
  ,
  output logic               o_err
`endif
);

  import alu_pkg::*;

  logic [SIZE-1:0]    sw_meta_q, sw_sync_q;
  logic               pulse_a, pulse_b, pulse_op;
  logic               op_ok_c;
  logic [SIZE-1:0]    a_q, a_d, b_q, b_d;
  logic [OP_SIZE-1:0] op_q, op_d;
  logic [2:0]         loaded_q, loaded_d;
  loader_state_e      state_q, state_d;
  logic               valid_q, valid_d;

  // Switch bus synchronizer; every capture uses the synchronized value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= i_sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_a), .o_pulse(pulse_a)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_b), .o_pulse(pulse_b)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_op (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_op), .o_pulse(pulse_op)
  );

`ifdef ALU_LOADER_OPCODE_CHECK_EN
  assign op_ok_c = is_valid_opcode(sw_sync_q[OP_SIZE-1:0]);

  logic err_q;

  // One-cycle error strobe for a rejected opcode load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= pulse_op & ~op_ok_c;
  end

  assign o_err = err_q;
`else
  assign op_ok_c = 1'b1;
`endif

  // Handshake FSM next state plus field captures; a load beats a consume.
  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;

    case (state_q)
      COLLECT: begin
        if (loaded_q == 3'b111) state_d = VALID;
      end
      VALID: begin
        if (i_ready) begin
          state_d  = COLLECT;
          loaded_d = 3'b000;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (pulse_a) begin
      a_d         = sw_sync_q;
      loaded_d[0] = 1'b1;
    end
    if (pulse_b) begin
      b_d         = sw_sync_q;
      loaded_d[1] = 1'b1;
    end
    if (pulse_op && op_ok_c) begin
      op_d        = sw_sync_q[OP_SIZE-1:0];
      loaded_d[2] = 1'b1;
    end

    valid_d = (state_d == VALID);
  end

  // State, operand and flag registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= COLLECT;
      loaded_q <= 3'b000;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      valid_q  <= valid_d;
    end
  end

  assign o_a      = a_q;
  assign o_b      = b_q;
  assign o_opcode = op_q;
  assign o_valid  = valid_q;
  assign o_loaded = loaded_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader with a short debounce window.
module tb_alu_operand_loader;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [8:0] i_sw = '0;
  logic       i_btn_a = 1'b0, i_btn_b = 1'b0, i_btn_op = 1'b0, i_ready = 1'b0;
  logic [8:0] o_a, o_b;
  logic [5:0] o_opcode;
  logic       o_valid;
  logic [2:0] o_loaded;
`ifdef ALU_LOADER_OPCODE_CHECK_EN
  logic       o_err;
`endif

  int n_chk = 0;
  int n_fail = 0;

  alu_operand_loader #(.SIZE(9), .OP_SIZE(6), .DEBOUNCE_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sw(i_sw),
    .i_btn_a(i_btn_a), .i_btn_b(i_btn_b), .i_btn_op(i_btn_op),
    .i_ready(i_ready),
    .o_a(o_a), .o_b(o_b), .o_opcode(o_opcode),
    .o_valid(o_valid), .o_loaded(o_loaded)
`ifdef ALU_LOADER_OPCODE_CHECK_EN
    , .o_err(o_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [8:0] a_sw;
    logic [8:0] b_sw;
    logic [8:0] op_sw;
    logic [5:0] op_exp;
    int         sum;
  } vec_t;

  typedef struct {
    logic [8:0] a;
    logic [8:0] b;
    logic [5:0] op;
  } trip_t;

  vec_t  vecs[4];
  trip_t sb_q[$];

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       i_btn_a  = v;
      1:       i_btn_b  = v;
      default: i_btn_op = v;
    endcase
  endtask

  // Full press: present switches, hold, release and let the release settle.
  task automatic press(input int which, input logic [8:0] sw, input int hold);
    i_sw = sw;
    tick(3);
    set_btn(which, 1'b1);
    tick(hold);
    set_btn(which, 1'b0);
    tick(10);
  endtask

  // Load the opcode last, check valid timing and pop the scoreboard.
  task automatic load_op_valid(input logic [8:0] sw, input int exp_sum);
    bit    seen = 0;
    trip_t e;
    int    s;
    i_sw = sw;
    tick(3);
    i_btn_op = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (o_loaded == 3'b111) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      chk("op_load_timeout", 32'(o_loaded), 32'd7);
    end else begin
      chk("valid_lag_low", 32'(o_valid), 32'd0);
      tick(1);
      chk("valid_rise", 32'(o_valid), 32'd1);
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("sb_a", 32'(o_a), 32'(e.a));
        chk("sb_b", 32'(o_b), 32'(e.b));
        chk("sb_op", 32'(o_opcode), 32'(e.op));
        s = int'($signed(o_a)) + int'($signed(o_b));
        chk("alu_sum", 32'(s), 32'(exp_sum));
      end
    end
    i_btn_op = 1'b0;
    tick(10);
  endtask

  initial begin
    int errs;
    vecs[0] = '{a_sw: 9'h005, b_sw: 9'h1FD, op_sw: 9'h020, op_exp: 6'b100000, sum: 2};
    vecs[1] = '{a_sw: 9'h0FF, b_sw: 9'h100, op_sw: 9'h022, op_exp: 6'b100010, sum: -1};
    vecs[2] = '{a_sw: 9'h1FF, b_sw: 9'h1FF, op_sw: 9'h1E4, op_exp: 6'b100100, sum: -2};
    vecs[3] = '{a_sw: 9'h000, b_sw: 9'h07F, op_sw: 9'h003, op_exp: 6'b000011, sum: 127};

    // Reset state
    tick(2);
    chk("rst_a", 32'(o_a), 32'd0);
    chk("rst_b", 32'(o_b), 32'd0);
    chk("rst_op", 32'(o_opcode), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_loaded", 32'(o_loaded), 32'd0);
`ifdef ALU_LOADER_OPCODE_CHECK_EN
    chk("rst_err", 32'(o_err), 32'd0);
`endif
    i_rst_n = 1'b1;
    tick(2);

    // Held A button: one capture only, later switch change must not load
    i_sw = 9'h0F5;
    tick(3);
    i_btn_a = 1'b1;
    tick(10);
    chk("hold_a_val", 32'(o_a), 32'h0F5);
    chk("hold_a_loaded", 32'(o_loaded), 32'b001);
    chk("hold_a_valid", 32'(o_valid), 32'd0);
    i_sw = 9'h1AA;
    tick(10);
    chk("hold_a_single", 32'(o_a), 32'h0F5);
    i_btn_a = 1'b0;
    tick(10);

    // Table-driven triples with consume
    for (int i = 0; i < 4; i++) begin
      press(0, vecs[i].a_sw, 12);
      press(1, vecs[i].b_sw, 12);
      sb_q.push_back('{a: vecs[i].a_sw, b: vecs[i].b_sw, op: vecs[i].op_exp});
      load_op_valid(vecs[i].op_sw, vecs[i].sum);
      i_ready = 1'b1;
      tick(1);
      i_ready = 1'b0;
      chk("consume_valid", 32'(o_valid), 32'd0);
      chk("consume_loaded", 32'(o_loaded), 32'd0);
      chk("consume_keep_a", 32'(o_a), 32'(vecs[i].a_sw));
      chk("consume_keep_b", 32'(o_b), 32'(vecs[i].b_sw));
      chk("consume_keep_op", 32'(o_opcode), 32'(vecs[i].op_exp));
      tick(2);
    end

    // Short glitches on B must not load
    for (int g = 0; g < 10; g++) begin
      i_sw = 9'h0AA;
      i_btn_b = 1'b1;
      tick(2);
      i_btn_b = 1'b0;
      tick(4);
    end
    tick(10);
    chk("glitch_loaded_b", 32'(o_loaded[1]), 32'd0);
    chk("glitch_b_keep", 32'(o_b), 32'h07F);

    // Overwrite while valid, then load and consume in the same cycle
    press(0, 9'h005, 12);
    press(1, 9'h1FD, 12);
    sb_q.push_back('{a: 9'h005, b: 9'h1FD, op: 6'b100000});
    load_op_valid(9'h020, 2);
    press(1, 9'h033, 12);
    chk("ovr_b", 32'(o_b), 32'h033);
    chk("ovr_valid", 32'(o_valid), 32'd1);
    chk("ovr_loaded", 32'(o_loaded), 32'b111);
    i_sw = 9'h0AB;
    tick(3);
    i_btn_a = 1'b1;
    tick(6);
    i_ready = 1'b1;
    tick(1);
    i_ready = 1'b0;
    tick(1);
    chk("same_cyc_loaded", 32'(o_loaded), 32'b001);
    chk("same_cyc_valid", 32'(o_valid), 32'd0);
    chk("same_cyc_a", 32'(o_a), 32'h0AB);
    chk("same_cyc_b", 32'(o_b), 32'h033);
    i_btn_a = 1'b0;
    tick(10);
    i_ready = 1'b1;
    tick(3);
    i_ready = 1'b0;
    chk("ready_ignored_loaded", 32'(o_loaded), 32'b001);
    chk("ready_ignored_valid", 32'(o_valid), 32'd0);

    // Reset mid-debounce with button held through release
    i_btn_a = 1'b1;
    tick(3);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_a", 32'(o_a), 32'd0);
    chk("mid_rst_b", 32'(o_b), 32'd0);
    chk("mid_rst_op", 32'(o_opcode), 32'd0);
    chk("mid_rst_loaded", 32'(o_loaded), 32'd0);
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    tick(2);
    i_sw = 9'h155;
    i_rst_n = 1'b1;
    tick(12);
    chk("post_rst_a", 32'(o_a), 32'h155);
    chk("post_rst_loaded", 32'(o_loaded), 32'b001);
    i_sw = 9'h0C3;
    tick(8);
    chk("post_rst_single", 32'(o_a), 32'h155);
    i_btn_a = 1'b0;
    tick(10);

`ifdef ALU_LOADER_OPCODE_CHECK_EN
    // Unsupported opcode rejected with one error strobe
    i_sw = 9'h03F;
    tick(3);
    i_btn_op = 1'b1;
    errs = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (o_err) errs++;
    end
    chk("err_pulses", 32'(errs), 32'd1);
    chk("err_op_keep", 32'(o_opcode), 32'd0);
    chk("err_loaded_op", 32'(o_loaded[2]), 32'd0);
    i_btn_op = 1'b0;
    tick(10);
    press(2, 9'h003, 12);
    chk("sra_accept_op", 32'(o_opcode), 32'h03);
    chk("sra_accept_loaded", 32'(o_loaded[2]), 32'd1);
`else
    // Any opcode value accepted without the check
    errs = 0;
    press(2, 9'h03F, 12);
    chk("any_op_accept", 32'(o_opcode), 32'h3F);
    chk("any_op_loaded", 32'(o_loaded[2]), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
